div_seq: RTL and testbench

//  Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU, replacing the single-cycle combinational divider on the EX path.

---
 rtl/div_seq_pkg.sv | 65 ++++++
 rtl/div_step.sv | 34 +++
 rtl/div_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_div_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// ----------------------------------------------------------------------------
// div_seq_pkg
//   Shared definitions for the sequential RV32M divider:
//   - ALU control codes of the divide class (DIV/DIVU/REM/REMU)
//   - FSM state encoding (2-bit)
//   - internal operation kind and per-operation context
//   - small decode helpers used at operation accept
// ----------------------------------------------------------------------------
package div_seq_pkg;

  localparam int unsigned ALU_CTRL_W = 5;

  // Divide-class ALU control codes, as driven by the decoder on alu_ctrl.
  localparam logic [ALU_CTRL_W-1:0] ALU_DIV  = 5'b01100;
  localparam logic [ALU_CTRL_W-1:0] ALU_DIVU = 5'b01101;
  localparam logic [ALU_CTRL_W-1:0] ALU_REM  = 5'b01110;
  localparam logic [ALU_CTRL_W-1:0] ALU_REMU = 5'b01111;

  typedef enum logic [1:0] {
    DIVS_IDLE  = 2'd0,
    DIVS_CALC  = 2'd1,
    DIVS_FIXUP = 2'd2,
    DIVS_DONE  = 2'd3
  } divs_state_e;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  // Everything about the operation that must survive until FIXUP.
  typedef struct packed {
    div_op_e op;
    logic    sign_a;
    logic    sign_b;
  } div_ctx_t;

  function automatic logic is_div_ctrl(input logic [ALU_CTRL_W-1:0] ctrl);
    return (ctrl == ALU_DIV) || (ctrl == ALU_DIVU) ||
           (ctrl == ALU_REM) || (ctrl == ALU_REMU);
  endfunction

  // Only meaningful when is_div_ctrl(ctrl) is true.
  function automatic div_op_e decode_op(input logic [ALU_CTRL_W-1:0] ctrl);
    div_op_e op;
    case (ctrl)
      ALU_DIV:  op = OP_DIV;
      ALU_DIVU: op = OP_DIVU;
      ALU_REM:  op = OP_REM;
      default:  op = OP_REMU;
    endcase
    return op;
  endfunction

  function automatic logic op_is_signed(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division step. Shifts the next dividend bit
//   into the partial remainder and subtracts the divisor if it fits.
// Ports
//   r_in   in  XLEN  partial remainder before the step (always < d)
//   a_bit  in  1     next dividend bit, MSB first
//   d      in  XLEN  divisor magnitude
//   r_out  out XLEN  partial remainder after the step
//   q_bit  out 1     quotient bit produced by this step
// ----------------------------------------------------------------------------
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] r_in,
  input  logic            a_bit,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] r_out,
  output logic            q_bit
);

  // The shifted remainder can reach 2*d-1, which needs one bit more than
  // XLEN; comparing and subtracting at XLEN+1 bits keeps it exact.
  logic [XLEN:0] r_shift;
  logic [XLEN:0] r_sub;

  assign r_shift = {r_in, a_bit};
  assign r_sub   = r_shift - {1'b0, d};
  assign q_bit   = (r_shift >= {1'b0, d});
  // After a successful subtract the result is < d, so the top bit is zero;
  // without a subtract r_shift < d as well. Either way XLEN bits suffice.
  assign r_out   = q_bit ? r_sub[XLEN-1:0] : r_shift[XLEN-1:0];

endmodule

// File: rtl/div_seq.sv
// ----------------------------------------------------------------------------
// div_seq
//   Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU. Latches operand
//   magnitudes on accept, runs an iterative restoring divide resolving UNROLL
//   quotient bits per CALC cycle, applies the sign fixup, then pulses done
//   with the result. Divide-by-zero and signed overflow resolve at accept and
//   skip CALC entirely.
// Parameters
//   XLEN    operand/result width
//   UNROLL  quotient bits per CALC cycle; 1, 2 or 4, and must divide XLEN
// Ports
//   clk       in   1     clock, rising edge
//   rst_n     in   1     asynchronous active-low reset
//   start     in   1     request; honoured only in IDLE or DONE
//   flush     in   1     abort the operation in flight
//   alu_ctrl  in   5     ALU_DIV/ALU_DIVU/ALU_REM/ALU_REMU; sampled with start
//   op_a      in   XLEN  dividend; sampled with start
//   op_b      in   XLEN  divisor; sampled with start
//   busy      out  1     operation in flight (CALC or FIXUP)
//   done      out  1     one-cycle pulse, result valid this cycle
//   result    out  XLEN  quotient or remainder; held until overwritten
// ----------------------------------------------------------------------------
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  flush,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic [XLEN-1:0]       op_a,
  input  logic [XLEN-1:0]       op_b,
  output logic                  busy,
  output logic                  done,
  output logic [XLEN-1:0]       result
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  divs_state_e     state_q,  state_d;
  div_ctx_t        ctx_q,    ctx_d;
  logic [XLEN-1:0] a_q,      a_d;       // dividend magnitude, shifted left as bits are consumed
  logic [XLEN-1:0] d_q,      d_d;       // divisor magnitude
  logic [XLEN-1:0] r_q,      r_d;       // partial remainder
  logic [XLEN-1:0] q_q,      q_d;       // quotient, built MSB first
  logic [CNT_W-1:0] cnt_q,   cnt_d;     // quotient bits resolved so far
  logic            done_q,   done_d;
  logic [XLEN-1:0] result_q, result_d;

  // --------------------------------------------------------------------------
  // Unrolled restoring steps: stage i consumes dividend bit XLEN-1-i of a_q.
  // --------------------------------------------------------------------------
  logic [UNROLL-1:0] q_bits;
  logic [XLEN-1:0]   r_next;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    logic [XLEN-1:0] r_in;
    logic [XLEN-1:0] r_out;

    if (i == 0) begin : g_first
      assign r_in = r_q;
    end else begin : g_chain
      assign r_in = g_step[i-1].r_out;
    end

    div_step #(.XLEN(XLEN)) u_step (
      .r_in  (r_in),
      .a_bit (a_q[XLEN-1-i]),
      .d     (d_q),
      .r_out (r_out),
      .q_bit (q_bits[UNROLL-1-i])
    );
  end

  assign r_next = g_step[UNROLL-1].r_out;

  // --------------------------------------------------------------------------
  // Accept decode
  // --------------------------------------------------------------------------
  div_op_e         acc_op;
  logic            acc_signed;
  logic            acc_rem;
  logic            acc_zero;
  logic            acc_ovf;
  logic [XLEN-1:0] acc_special_res;
  logic            can_accept;
  logic            accept;

  assign acc_op     = decode_op(alu_ctrl);
  assign acc_signed = op_is_signed(acc_op);
  assign acc_rem    = op_is_rem(acc_op);
  assign acc_zero   = (op_b == '0);
  assign acc_ovf    = acc_signed && (op_a == INT_MIN) && (op_b == '1);

  always_comb begin
    acc_special_res = '0;
    if (acc_zero) begin
      acc_special_res = acc_rem ? op_a : '1;
    end else if (acc_ovf) begin
      acc_special_res = acc_rem ? '0 : INT_MIN;
    end
  end

  // Flush always wins over a same-cycle start, including in DONE.
  assign can_accept = (state_q == DIVS_IDLE) || (state_q == DIVS_DONE);
  assign accept     = can_accept && start && !flush && is_div_ctrl(alu_ctrl);

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_step;
  logic [XLEN-1:0]  q_fixed;
  logic [XLEN-1:0]  r_fixed;

  assign cnt_step = cnt_q + CNT_W'(UNROLL);
  assign q_fixed  = (ctx_q.sign_a ^ ctx_q.sign_b) ? -q_q : q_q;
  assign r_fixed  = ctx_q.sign_a ? -r_q : r_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    ctx_d    = ctx_q;
    a_d      = a_q;
    d_d      = d_q;
    r_d      = r_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      DIVS_IDLE, DIVS_DONE: begin
        state_d = DIVS_IDLE;
        if (accept) begin
          ctx_d.op     = acc_op;
          ctx_d.sign_a = acc_signed & op_a[XLEN-1];
          ctx_d.sign_b = acc_signed & op_b[XLEN-1];
          a_d          = (acc_signed && op_a[XLEN-1]) ? -op_a : op_a;
          d_d          = (acc_signed && op_b[XLEN-1]) ? -op_b : op_b;
          r_d          = '0;
          q_d          = '0;
          cnt_d        = '0;
          if (acc_zero || acc_ovf) begin
            state_d  = DIVS_DONE;
            done_d   = 1'b1;
            result_d = acc_special_res;
          end else begin
            state_d = DIVS_CALC;
          end
        end
      end

      DIVS_CALC: begin
        if (flush) begin
          state_d = DIVS_IDLE;
        end else begin
          a_d   = a_q << UNROLL;
          r_d   = r_next;
          q_d   = {q_q[XLEN-UNROLL-1:0], q_bits};
          cnt_d = cnt_step;
          if (cnt_step == CNT_W'(XLEN)) begin
            state_d = DIVS_FIXUP;
          end
        end
      end

      DIVS_FIXUP: begin
        if (flush) begin
          state_d = DIVS_IDLE;
        end else begin
          state_d = DIVS_DONE;
          done_d  = 1'b1;
          case (ctx_q.op)
            OP_DIV:  result_d = q_fixed;
            OP_REM:  result_d = r_fixed;
            OP_DIVU: result_d = q_q;
            default: result_d = r_q;
          endcase
        end
      end

      default: state_d = DIVS_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIVS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: datapath registers are reset too, so an operation cut off by reset
  // leaves nothing behind and result reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx_q    <= '0;
      a_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      ctx_q    <= ctx_d;
      a_q      <= a_d;
      d_q      <= d_d;
      r_q      <= r_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == DIVS_CALC) || (state_q == DIVS_FIXUP);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_seq.sv
// ----------------------------------------------------------------------------
// tb_div_seq
//   Three div_seq instances (UNROLL = 1, 2, 4), each with its own inputs,
//   exercised one at a time by directed steps and random operands. Expected
//   results come from a plain-arithmetic model of the RISC-V divide rules;
//   expected timing comes from the documented latencies.
// ----------------------------------------------------------------------------
module tb_div_seq;
  import div_seq_pkg::*;

  localparam int XLEN  = 32;
  localparam int N_DUT = 3;
  localparam int N_RAND = 800;

  logic                  clk;
  logic                  rst_n;
  logic                  start_v    [N_DUT];
  logic                  flush_v    [N_DUT];
  logic [ALU_CTRL_W-1:0] ctrl_v     [N_DUT];
  logic [XLEN-1:0]       a_v        [N_DUT];
  logic [XLEN-1:0]       b_v        [N_DUT];
  logic                  busy_v     [N_DUT];
  logic                  done_v     [N_DUT];
  logic [XLEN-1:0]       result_v   [N_DUT];

  logic [XLEN-1:0]       last_res   [N_DUT];

  int checks;
  int errors;

  div_seq #(.XLEN(XLEN), .UNROLL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .flush(flush_v[0]),
    .alu_ctrl(ctrl_v[0]), .op_a(a_v[0]), .op_b(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .result(result_v[0]));

  div_seq #(.XLEN(XLEN), .UNROLL(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .flush(flush_v[1]),
    .alu_ctrl(ctrl_v[1]), .op_a(a_v[1]), .op_b(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .result(result_v[1]));

  div_seq #(.XLEN(XLEN), .UNROLL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .flush(flush_v[2]),
    .alu_ctrl(ctrl_v[2]), .op_a(a_v[2]), .op_b(b_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .result(result_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic int unroll_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_special(input logic [4:0] c, input logic [31:0] a,
                                    input logic [31:0] b);
    bit sgn;
    sgn = (c == ALU_DIV) || (c == ALU_REM);
    return (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [4:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      return ((c == ALU_REM) || (c == ALU_REMU)) ? a : 32'hFFFF_FFFF;
    end
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      if (c == ALU_DIV) return 32'h8000_0000;
      if (c == ALU_REM) return 32'h0;
    end
    case (c)
      ALU_DIV:  return sa / sb;
      ALU_REM:  return sa % sb;
      ALU_DIVU: return a / b;
      default:  return a % b;
    endcase
  endfunction

  function automatic int latency(input int k, input logic [4:0] c,
                                 input logic [31:0] a, input logic [31:0] b);
    return is_special(c, a, b) ? 1 : XLEN / unroll_of(k) + 2;
  endfunction

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int k, input string tag);
    check($sformatf("u%0d %s busy", unroll_of(k), tag), 32'(busy_v[k]), 32'd0);
    check($sformatf("u%0d %s done", unroll_of(k), tag), 32'(done_v[k]), 32'd0);
    check($sformatf("u%0d %s result", unroll_of(k), tag), result_v[k], last_res[k]);
  endtask

  // Issue one operation on instance k, starting right after a negedge.
  //   fc    : cycle in which flush is driven (0 = none)
  //   bc    : cycle in which a stray start is driven while busy (0 = none)
  //   chain : return at the done cycle so the caller can start again in it
  task automatic issue(input int k, input logic [4:0] c, input logic [31:0] a,
                       input logic [31:0] b, input int fc, input int bc, input bit chain);
    int lat;
    bit flushed;
    int last_cyc;
    logic [31:0] exp;
    logic [31:0] old;
    lat      = latency(k, c, a, b);
    exp      = ref_div(c, a, b);
    old      = last_res[k];
    flushed  = (fc != 0) && (fc < lat);
    last_cyc = flushed ? fc + 2 : (chain ? lat : lat + 2);
    start_v[k] = 1'b1;
    ctrl_v[k]  = c;
    a_v[k]     = a;
    b_v[k]     = b;
    for (int cyc = 1; cyc <= last_cyc; cyc++) begin
      @(negedge clk);
      start_v[k] = 1'b0;
      flush_v[k] = 1'b0;
      if (flushed && cyc > fc) begin
        check($sformatf("u%0d flushed busy c%0d", unroll_of(k), cyc), 32'(busy_v[k]), 32'd0);
        check($sformatf("u%0d flushed done c%0d", unroll_of(k), cyc), 32'(done_v[k]), 32'd0);
        check($sformatf("u%0d flushed result c%0d", unroll_of(k), cyc), result_v[k], old);
      end else begin
        check($sformatf("u%0d busy c%0d", unroll_of(k), cyc), 32'(busy_v[k]), 32'(cyc < lat));
        check($sformatf("u%0d done c%0d", unroll_of(k), cyc), 32'(done_v[k]), 32'(cyc == lat));
        if (cyc >= lat) begin
          check($sformatf("u%0d result %h/%h op%h c%0d", unroll_of(k), a, b, c, cyc),
                result_v[k], exp);
        end
      end
      if (cyc == fc) flush_v[k] = 1'b1;
      if (cyc == bc) begin
        start_v[k] = 1'b1;
        ctrl_v[k]  = ALU_REMU;
        a_v[k]     = 32'd1234;
        b_v[k]     = 32'd0;
      end
    end
    if (!flushed) last_res[k] = exp;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int k = 0; k < N_DUT; k++) begin
      start_v[k]  = 1'b0;
      flush_v[k]  = 1'b0;
      ctrl_v[k]   = '0;
      a_v[k]      = '0;
      b_v[k]      = '0;
      last_res[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < N_DUT; k++) check_idle(k, "in reset");
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N_DUT; k++) check_idle(k, "after reset");

    for (int k = 0; k < N_DUT; k++) begin
      // Basic unsigned divide and remainder
      issue(k, ALU_DIVU, 32'd100, 32'd7, 0, 0, 0);
      issue(k, ALU_REMU, 32'd100, 32'd7, 0, 0, 0);
      // Signed sign combinations
      issue(k, ALU_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
      issue(k, ALU_REM, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
      issue(k, ALU_DIV, 32'd7, 32'hFFFF_FFFE, 0, 0, 0);
      issue(k, ALU_REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, 0, 0);
      // Special cases
      issue(k, ALU_DIV, 32'd5, 32'd0, 0, 0, 0);
      issue(k, ALU_REMU, 32'd5, 32'd0, 0, 0, 0);
      issue(k, ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
      issue(k, ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
      // Unsigned view of the overflow pattern is an ordinary divide
      issue(k, ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
      // Flush mid-operation, then a clean follow-up
      issue(k, ALU_DIVU, 32'd1000, 32'd3, 10, 0, 0);
      issue(k, ALU_DIVU, 32'd9, 32'd3, 0, 0, 0);
      // Flush in FIXUP
      issue(k, ALU_DIV, 32'hFFFF_FF00, 32'd3, XLEN / unroll_of(k) + 1, 0, 0);
      // Stray start while busy must be ignored
      issue(k, ALU_DIVU, 32'd12345, 32'd10, 0, 5, 0);
      // Back-to-back accepts in the DONE cycle, mixing special and normal
      issue(k, ALU_DIVU, 32'd100, 32'd7, 0, 0, 1);
      issue(k, ALU_REM, 32'hFFFF_FFF9, 32'd2, 0, 0, 1);
      issue(k, ALU_DIV, 32'd5, 32'd0, 0, 0, 1);
      issue(k, ALU_REMU, 32'd17, 32'd5, 0, 0, 1);
      // Flush with start in the DONE cycle: done already shown, start dropped
      flush_v[k] = 1'b1;
      start_v[k] = 1'b1;
      ctrl_v[k]  = ALU_DIVU;
      a_v[k]     = 32'd100;
      b_v[k]     = 32'd0;
      @(negedge clk);
      flush_v[k] = 1'b0;
      start_v[k] = 1'b0;
      check_idle(k, "flush+start in done");
      // Flush with start in IDLE: flush wins
      flush_v[k] = 1'b1;
      start_v[k] = 1'b1;
      @(negedge clk);
      flush_v[k] = 1'b0;
      start_v[k] = 1'b0;
      check_idle(k, "flush+start in idle");
      @(negedge clk);
      check_idle(k, "flush+start in idle +1");
      // Non-divide alu_ctrl is ignored
      start_v[k] = 1'b1;
      ctrl_v[k]  = 5'b00000;
      @(negedge clk);
      start_v[k] = 1'b0;
      check_idle(k, "non-div ctrl");
      @(negedge clk);
      check_idle(k, "non-div ctrl +1");
    end

    // Reset in the middle of CALC on the UNROLL=1 instance
    start_v[0] = 1'b1;
    ctrl_v[0]  = ALU_DIVU;
    a_v[0]     = 32'd5000;
    b_v[0]     = 32'd7;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("u1 busy before reset", 32'(busy_v[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < N_DUT; k++) last_res[k] = '0;
    for (int k = 0; k < N_DUT; k++) check_idle(k, "async reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N_DUT; k++) check_idle(k, "after mid reset");
    issue(0, ALU_DIVU, 32'd9, 32'd3, 0, 0, 0);

    // Random operands, issued back to back
    for (int k = 0; k < N_DUT; k++) begin
      for (int i = 0; i < N_RAND; i++) begin
        logic [4:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        int sel;
        case ($urandom_range(0, 3))
          0:       c = ALU_DIV;
          1:       c = ALU_DIVU;
          2:       c = ALU_REM;
          default: c = ALU_REMU;
        endcase
        a   = $urandom;
        b   = $urandom;
        sel = $urandom_range(0, 15);
        if (sel == 0) b = 32'd0;
        else if (sel == 1) begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        else if (sel <= 5) b = $urandom_range(1, 255);
        else if (sel == 6) a = $urandom_range(0, 300);
        else if (sel == 7) b = -($urandom_range(1, 255));
        issue(k, c, a, b, 0, 0, (i != N_RAND - 1));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
